uart_frame_receiver: RTL
========================

Name: uart_frame_receiver

Overview:
Receive-side counterpart of the multi-byte UART frame sender. Consumes byte strobes from the byte-level UART receiver (RXDATA/RXDONE) and assembles BYTES consecutive bytes into one _D-bit word. Bytes arrive LSB byte first, matching the sender's shift-right order. An inter-byte timeout resynchronises on partial frames. Sits between the UART core's RX side and the application's frame consumer.

Parameters:
SCYCLE, 50_000_000, system clock frequency in Hz.
BAUDRATE, 9600, line baud rate.
BYTES, 8, data bytes per frame, range 1..32.
DWIDTH, 8, bits per byte.
TIMEOUT, 2*10*SCYCLE/BAUDRATE, inter-byte idle limit in clocks (about 2 byte times); minimum 2.
_D, BYTES*DWIDTH, frame width (derived, not overridden).

Ports:
iClock  in  1  system clock, rising edge.
iReset  in  1  asynchronous, active-high reset.
iRxData  in  DWIDTH  byte from UART RX, valid when iRxDone=1.
iRxDone  in  1  one-cycle byte-received strobe.
oRecvReception  out  1  high while a frame is partially received.
oRecvDatas  out  _D  last complete frame; byte k occupies [k*DWIDTH +: DWIDTH], first byte received = k=0.
oRecvDone  out  1  one-cycle pulse, frame complete.
oRecvTimeout  out  1  one-cycle pulse, partial frame discarded.
oRecvError  out  1  one-cycle pulse, checksum mismatch (0 without the optional feature).

Behaviour:
- Reset (asynchronous, iReset=1): state=IDLE, byte counter=0, timeout counter=0, shadow register=0, oRecvDatas=0, all pulse outputs=0, oRecvReception=0. Asserting reset mid-frame discards the frame with no pulse.
- Assembly uses a shadow register; oRecvDatas changes only on a successful completion and holds its value otherwise.
- FSM states: IDLE, RECV.
- IDLE:
  - iRxDone writes byte 0 and sets counter=1.
  - If the frame length is 1, the frame completes; otherwise go to RECV.
- RECV:
  - iRxDone writes byte at index counter and increments counter.
  - When the written index is the last frame byte, the frame completes and the FSM returns to IDLE with counter=0.
- Completion: in the cycle after the final iRxDone, oRecvDone=1 for exactly one cycle and oRecvDatas holds the new frame in that same cycle (registered, latency 1).
- Timeout:
  - In RECV, the timeout counter increments every cycle without iRxDone and clears on iRxDone.
  - When it reaches TIMEOUT-1: oRecvTimeout pulses next cycle, the shadow register and counter are cleared, and the FSM goes to IDLE.
- iRxDone in the same cycle as timeout expiry: the byte wins, with no timeout.
- The cycle after any pulse accepts a new iRxDone normally; back-to-back frames need no gap.
- oRecvReception = (state==RECV), registered.
- Byte counter is 5 bits wide plus 1 bit when the optional feature is on. No wrap: the counter resets on completion or timeout.

Optional Feature:
UART_FRAME_RX_CHECKSUM_EN
- Defined:
  - Frame length is BYTES+1; the extra trailing byte is a checksum.
  - Checksum = modulo-2^DWIDTH sum of the BYTES data bytes.
  - Match: oRecvDone pulses and oRecvDatas updates.
  - Mismatch: oRecvError pulses instead, oRecvDatas is unchanged, state returns to IDLE.
  - The checksum byte is not stored in oRecvDatas.
  - Timeout applies to the checksum byte too.
- Undefined:
  - Frame length is BYTES.
  - oRecvError is tied to 0.

Test Plan:
- BYTES=4, TIMEOUT=100: strobe 0x11,0x22,0x33,0x44 at 10-cycle spacing -> cycle after 4th strobe: oRecvDone=1 for one cycle, oRecvDatas=0x44332211, oRecvReception falls the same cycle.
- Send 2 bytes (0xAA,0xBB), then idle 100 cycles -> oRecvTimeout pulses once, oRecvDone stays 0, oRecvDatas keeps its previous value. Then send 0x01..0x04 -> 0x04030201.
- Back-to-back: frame 0x11..0x44 immediately followed by 0x55..0x88 with strobes every cycle -> two oRecvDone pulses 4 cycles apart; second oRecvDatas=0x88776655.
- iRxDone coincident with the 99th idle cycle -> no timeout, counter advances.
- Assert iReset after 3 bytes -> outputs 0 immediately. A full frame afterwards -> the correct frame, with no stale bytes.
- With UART_FRAME_RX_CHECKSUM_EN: 0x01,0x02,0x03,0x04,0x0A -> oRecvDone, 0x04030201. Same data with checksum 0x0B -> oRecvError pulse, oRecvDatas unchanged.

Source files
------------

// File: rtl/uart_frame_receiver_if.sv
// Byte-strobe input and frame-result output bundle for uart_frame_receiver.
// The master modport is the producer/consumer side; the slave modport is the receiver.
interface uart_frame_receiver_if #(
    parameter int DWIDTH = 8,
    parameter int FW     = 64
);
    logic [DWIDTH-1:0] iRxData;
    logic              iRxDone;
    logic              oRecvReception;
    logic [FW-1:0]     oRecvDatas;
    logic              oRecvDone;
    logic              oRecvTimeout;
    logic              oRecvError;

    modport master (
        output iRxData, iRxDone,
        input  oRecvReception, oRecvDatas, oRecvDone, oRecvTimeout, oRecvError
    );

    modport slave (
        input  iRxData, iRxDone,
        output oRecvReception, oRecvDatas, oRecvDone, oRecvTimeout, oRecvError
    );
endinterface

// File: rtl/uart_frame_receiver.sv
// Assembles BYTES UART bytes (LSB byte first) into one frame, with an inter-byte timeout.
// Define UART_FRAME_RX_CHECKSUM_EN to expect a trailing modulo-2^DWIDTH sum byte per frame.
module uart_frame_receiver #(
    parameter int SCYCLE   = 50_000_000,
    parameter int BAUDRATE = 9600,
    parameter int BYTES    = 8,
    parameter int DWIDTH   = 8,
    parameter int TIMEOUT  = 2 * 10 * SCYCLE / BAUDRATE
) (
    input logic                  iClock,
    input logic                  iReset,
    uart_frame_receiver_if.slave rx
);
    localparam int FRAME_W = BYTES * DWIDTH;
`ifdef UART_FRAME_RX_CHECKSUM_EN
    localparam int FRAME_LEN = BYTES + 1;
    localparam int CW        = 6;
`else
    localparam int FRAME_LEN = BYTES;
    localparam int CW        = 5;
`endif
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t               state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s, idx_s;
    logic [TW-1:0]        tmo_r, tmo_s;
    logic [FRAME_W-1:0]   shadow_r, shadow_s;
    logic [FRAME_W-1:0]   datas_r, datas_s;
    logic                 done_r, done_s;
    logic                 timeout_r, timeout_s;
    logic                 reception_r;
`ifdef UART_FRAME_RX_CHECKSUM_EN
    logic [DWIDTH-1:0]    sum_r, sum_s;
    logic                 error_r, error_s;
`endif

    // Next-state, byte placement, completion and timeout decisions.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        tmo_s     = '0;
        shadow_s  = shadow_r;
        datas_s   = datas_r;
        done_s    = 1'b0;
        timeout_s = 1'b0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
        sum_s     = sum_r;
        error_s   = 1'b0;
`endif
        idx_s = (state_r == RECV) ? cnt_r : '0;
        if (rx.iRxDone) begin
            if (int'(idx_s) < BYTES) begin
                shadow_s[int'(idx_s)*DWIDTH +: DWIDTH] = rx.iRxData;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                sum_s = (state_r == RECV) ? DWIDTH'(sum_r + rx.iRxData) : rx.iRxData;
`endif
            end else begin
                shadow_s = shadow_r;
            end
            if (idx_s == CW'(FRAME_LEN - 1)) begin
`ifdef UART_FRAME_RX_CHECKSUM_EN
                // The checksum byte itself never lands in the frame.
                if (rx.iRxData == sum_r) begin
                    done_s  = 1'b1;
                    datas_s = shadow_r;
                end else begin
                    error_s = 1'b1;
                end
`else
                done_s  = 1'b1;
                datas_s = shadow_s;
`endif
                state_s  = IDLE;
                cnt_s    = '0;
                shadow_s = '0;
            end else begin
                state_s = RECV;
                cnt_s   = idx_s + CW'(1);
            end
        end else if (state_r == RECV) begin
            if (tmo_r == TW'(TIMEOUT - 1)) begin
                timeout_s = 1'b1;
                state_s   = IDLE;
                cnt_s     = '0;
                shadow_s  = '0;
            end else begin
                tmo_s = tmo_r + TW'(1);
            end
        end else begin
            tmo_s = '0;
        end
    end

    // State, assembly and output registers.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            tmo_r       <= '0;
            shadow_r    <= '0;
            datas_r     <= '0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            reception_r <= 1'b0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
            sum_r       <= '0;
            error_r     <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            tmo_r       <= tmo_s;
            shadow_r    <= shadow_s;
            datas_r     <= datas_s;
            done_r      <= done_s;
            timeout_r   <= timeout_s;
            reception_r <= (state_s == RECV);
`ifdef UART_FRAME_RX_CHECKSUM_EN
            sum_r       <= sum_s;
            error_r     <= error_s;
`endif
        end
    end

    assign rx.oRecvReception = reception_r;
    assign rx.oRecvDatas     = datas_r;
    assign rx.oRecvDone      = done_r;
    assign rx.oRecvTimeout   = timeout_r;
`ifdef UART_FRAME_RX_CHECKSUM_EN
    assign rx.oRecvError     = error_r;
`else
    assign rx.oRecvError     = 1'b0;
`endif
endmodule
